// File: rtl/axi_wr_slave_ram.sv
// AXI3 write-channel responder terminating 64-bit INCR bursts into an on-chip word memory,
// with registered readback and capture counters. Optional range check: AXI_WR_SLAVE_RANGE_CHK_EN.
module axi_wr_slave_ram #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256
) (
    input  logic                           aclk,
    input  logic                           rst_ni,
    input  logic [31:0]                    s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [3:0]                     s_axi_awlen,
    input  logic [2:0]                     s_axi_awsize,
    input  logic [1:0]                     s_axi_awburst,
    input  logic [63:0]                    s_axi_wdata,
    input  logic [7:0]                     s_axi_wstrb,
    input  logic                           s_axi_wlast,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    output logic [1:0]                     s_axi_bresp,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr_i,
    output logic [63:0]                    rd_data_o,
    output logic [31:0]                    beat_count_o,
    output logic [15:0]                    burst_count_o,
    output logic                           proto_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] start_q, start_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    beat_q, beat_d;
    logic          err_q, err_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [31:0]   beat_count_q, beat_count_d;
    logic [15:0]   burst_count_q, burst_count_d;
    logic          proto_err_q, proto_err_d;
    logic [63:0]   rd_data_q;
    logic [63:0]   mem_q [DEPTH_WORDS];

    logic          aw_hs_s, w_hs_s, b_hs_s;
    logic          unsup_s, range_err_s, last_beat_s, wr_en_s;
    logic [31:0]   offset_s;
    logic [AW-1:0] wr_addr_s;
    logic          unused_s;

    assign aw_hs_s     = s_axi_awvalid & awready_q;
    assign w_hs_s      = s_axi_wvalid & wready_q;
    assign b_hs_s      = bvalid_q & s_axi_bready;
    assign offset_s    = s_axi_awaddr - ADDR_BASE;
    assign unsup_s     = (s_axi_awsize != 3'b011) | (s_axi_awburst != 2'b01);
    assign last_beat_s = (beat_q == len_q);
    assign wr_en_s     = w_hs_s & ~err_q;
    assign wr_addr_s   = start_q + AW'(beat_q);
    assign unused_s    = ^offset_s;

`ifdef AXI_WR_SLAVE_RANGE_CHK_EN
    logic [29:0] end_word_s;
    assign end_word_s  = {1'b0, offset_s[31:3]} + {26'd0, s_axi_awlen};
    assign range_err_s = (s_axi_awaddr < ADDR_BASE) | (end_word_s >= 30'(DEPTH_WORDS));
`else
    assign range_err_s = 1'b0;
`endif

    // Burst sequencing, error tracking and counter next-state.
    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        len_d         = len_q;
        beat_d        = beat_q;
        err_d         = err_q;
        bresp_d       = bresp_q;
        proto_err_d   = proto_err_q;
        beat_count_d  = beat_count_q;
        burst_count_d = burst_count_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    start_d     = offset_s[AW+2:3];
                    len_d       = s_axi_awlen;
                    beat_d      = 4'd0;
                    err_d       = unsup_s | range_err_s;
                    proto_err_d = proto_err_q | unsup_s;
                    state_d     = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_hs_s) begin
                    beat_count_d = beat_count_q + 32'd1;
                    beat_d       = beat_q + 4'd1;
                    // wlast is only checked, never obeyed: awlen alone ends the burst.
                    proto_err_d  = proto_err_q | (s_axi_wlast ^ last_beat_s);
                    if (last_beat_s) begin
                        bresp_d = err_q ? 2'b10 : 2'b00;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (b_hs_s) begin
                    burst_count_d = burst_count_q + 16'd1;
                    bresp_d       = 2'b00;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        awready_d = (state_d == ST_IDLE);
        wready_d  = (state_d == ST_DATA);
        bvalid_d  = (state_d == ST_RESP);
    end

    // Control state, registered handshake outputs, counters and readback.
    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            start_q       <= '0;
            len_q         <= 4'd0;
            beat_q        <= 4'd0;
            err_q         <= 1'b0;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            beat_count_q  <= 32'd0;
            burst_count_q <= 16'd0;
            proto_err_q   <= 1'b0;
            rd_data_q     <= 64'd0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            err_q         <= err_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            beat_count_q  <= beat_count_d;
            burst_count_q <= burst_count_d;
            proto_err_q   <= proto_err_d;
            rd_data_q     <= mem_q[rd_addr_i];
        end
    end

    // Byte-masked memory write; contents are intentionally kept across reset.
    always_ff @(posedge aclk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[wr_addr_s][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign rd_data_o     = rd_data_q;
    assign beat_count_o  = beat_count_q;
    assign burst_count_o = burst_count_q;
    assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_axi_wr_slave_ram.sv
// Directed self-checking bench for axi_wr_slave_ram: bursts, backpressure, strobes,
// protocol errors, address range behaviour and reset in mid-burst.
module tb_axi_wr_slave_ram;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 256;

    logic        aclk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] awaddr = 32'd0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  awlen = 4'd0;
    logic [2:0]  awsize = 3'b011;
    logic [1:0]  awburst = 2'b01;
    logic [63:0] wdata = 64'd0;
    logic [7:0]  wstrb = 8'd0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  bresp;
    logic [7:0]  rd_addr = 8'd0;
    logic [63:0] rd_data;
    logic [31:0] beat_count;
    logic [15:0] burst_count;
    logic        proto_err;
    logic [1:0]  resp;

    int n_tests = 0;
    int n_fail  = 0;

    axi_wr_slave_ram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .aclk(aclk), .rst_ni(rst_ni),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .beat_count_o(beat_count), .burst_count_o(burst_count), .proto_err_o(proto_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input int idx, input logic [63:0] exp);
        rd_addr = idx[7:0];
        @(negedge aclk);
        chk($sformatf("rd[%0d]", idx), rd_data, exp);
    endtask

    task automatic rst_pulse();
        @(negedge aclk);
        rst_ni = 1'b0;
        @(negedge aclk);
        rst_ni = 1'b1;
        @(negedge aclk);
    endtask

    // Drives one burst from a negedge; beat i carries dbase+i. abort_at>=0 asserts reset before that beat.
    task automatic do_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [63:0] dbase, input logic [7:0] strb,
                            input int stall_mod, input int wlast_beat, input int bhold,
                            input int abort_at, output logic [1:0] rsp);
        int guard;
        int cyc;
        rsp = 2'b11;
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        guard = 0;
        while (awready !== 1'b1 && guard < 20) begin
            @(negedge aclk);
            guard++;
        end
        if (guard >= 20) begin
            chk("aw_timeout", 64'd0, 64'd1);
            awvalid = 1'b0;
            return;
        end
        @(negedge aclk);
        awvalid = 1'b0;
        chk("wready_rise", wready, 1'b1);
        chk("awready_fall", awready, 1'b0);
        cyc = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (stall_mod > 0 && (cyc % stall_mod) == stall_mod - 1) begin
                wvalid = 1'b0;
                @(negedge aclk);
                cyc++;
            end
            wdata = dbase + 64'(i); wstrb = strb; wlast = (i == wlast_beat); wvalid = 1'b1;
            if (i == abort_at) begin
                rst_ni = 1'b0;
                #1;
                wvalid = 1'b0;
                return;
            end
            guard = 0;
            while (wready !== 1'b1 && guard < 20) begin
                @(negedge aclk);
                guard++;
            end
            if (guard >= 20) begin
                chk("w_timeout", 64'd0, 64'd1);
                wvalid = 1'b0;
                return;
            end
            @(negedge aclk);
            cyc++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_rise", bvalid, 1'b1);
        chk("wready_fall", wready, 1'b0);
        for (int k = 0; k < bhold; k++) begin
            @(negedge aclk);
            chk("bvalid_hold", bvalid, 1'b1);
            chk("awready_hold", awready, 1'b0);
        end
        bready = 1'b1;
        rsp = bresp;
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_fall", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge aclk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_beats", beat_count, 32'd0);
        chk("rst_bursts", burst_count, 16'd0);
        chk("rst_proto", proto_err, 1'b0);
        rst_ni = 1'b1;
        @(negedge aclk);
        chk("awready_after_rst", awready, 1'b1);

        // Basic 16-beat burst at word 0
        do_burst(BASE, 4'd15, 3'b011, 2'b01, 64'd0, 8'hFF, 0, 15, 0, -1, resp);
        chk("basic_bresp", resp, 2'b00);
        chk("basic_beats", beat_count, 32'd16);
        chk("basic_bursts", burst_count, 16'd1);
        chk("basic_proto", proto_err, 1'b0);
        for (int i = 0; i < 16; i++) rd_check(i, 64'(i));

        // Backpressure: W stalls and a held B, landing at words 16..31
        do_burst(BASE + 32'd128, 4'd15, 3'b011, 2'b01, 64'd100, 8'hFF, 4, 15, 5, -1, resp);
        chk("bp_bresp", resp, 2'b00);
        chk("bp_beats", beat_count, 32'd32);
        chk("bp_bursts", burst_count, 16'd2);
        for (int i = 16; i < 32; i++) rd_check(i, 64'(100 + i - 16));

        // Byte strobes over a preloaded all-ones word
        do_burst(BASE, 4'd0, 3'b011, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0, -1, resp);
        do_burst(BASE, 4'd0, 3'b011, 2'b01, 64'd0, 8'h0F, 0, 0, 0, -1, resp);
        rd_check(0, 64'hFFFF_FFFF_0000_0000);
        chk("strb_beats", beat_count, 32'd34);

        // Early wlast on beat 3: flagged but the burst still runs 16 beats
        do_burst(BASE + 32'd256, 4'd15, 3'b011, 2'b01, 64'd200, 8'hFF, 0, 3, 0, -1, resp);
        chk("early_bresp", resp, 2'b00);
        chk("early_proto", proto_err, 1'b1);
        chk("early_beats", beat_count, 32'd50);
        rd_check(32, 64'd200);
        rd_check(47, 64'd215);

        rst_pulse();
        chk("rst2_proto", proto_err, 1'b0);
        chk("rst2_beats", beat_count, 32'd0);
        chk("rst2_bursts", burst_count, 16'd0);
        rd_check(1, 64'd1);
        rd_check(35, 64'd203);

        // Unsupported size: consumed, no writes, SLVERR
        do_burst(BASE + 32'd128, 4'd15, 3'b010, 2'b01, 64'd500, 8'hFF, 0, 15, 0, -1, resp);
        chk("size_bresp", resp, 2'b10);
        chk("size_proto", proto_err, 1'b1);
        chk("size_beats", beat_count, 32'd16);
        rd_check(16, 64'd100);
        rd_check(31, 64'd115);

        // FIXED burst type is unsupported as well
        rst_pulse();
        do_burst(BASE + 32'd128, 4'd0, 3'b011, 2'b00, 64'd600, 8'hFF, 0, 0, 0, -1, resp);
        chk("fixed_bresp", resp, 2'b10);
        chk("fixed_proto", proto_err, 1'b1);
        rd_check(16, 64'd100);

        // Missing wlast on the final beat
        rst_pulse();
        do_burst(BASE + 32'd16, 4'd0, 3'b011, 2'b01, 64'd42, 8'hFF, 0, -1, 0, -1, resp);
        chk("nolast_bresp", resp, 2'b00);
        chk("nolast_proto", proto_err, 1'b1);
        rd_check(2, 64'd42);

        // Burst crossing the top of memory
        rst_pulse();
        do_burst(BASE + 32'(8 * (DEPTH - 8)), 4'd15, 3'b011, 2'b01, 64'd1000, 8'hFF, 0, 15, 0, -1, resp);
        chk("range_proto", proto_err, 1'b0);
`ifdef AXI_WR_SLAVE_RANGE_CHK_EN
        chk("range_bresp", resp, 2'b10);
        rd_check(0, 64'hFFFF_FFFF_0000_0000);
        rd_check(7, 64'd7);
`else
        chk("range_bresp", resp, 2'b00);
        rd_check(DEPTH - 8, 64'd1000);
        rd_check(DEPTH - 1, 64'd1007);
        rd_check(0, 64'd1008);
        rd_check(7, 64'd1015);
`endif

        // Reset asserted at beat 5 of a burst to word 64
        rst_pulse();
        do_burst(BASE + 32'd512, 4'd15, 3'b011, 2'b01, 64'd2000, 8'hFF, 0, 15, 0, 5, resp);
        chk("abort_bvalid", bvalid, 1'b0);
        chk("abort_wready", wready, 1'b0);
        chk("abort_beats", beat_count, 32'd0);
        chk("abort_bursts", burst_count, 16'd0);
        @(negedge aclk);
        rst_ni = 1'b1;
        @(negedge aclk);
        chk("abort_awready", awready, 1'b1);
        chk("abort_no_b", bvalid, 1'b0);
        rd_check(64, 64'd2000);
        rd_check(68, 64'd2004);
        do_burst(BASE + 32'd560, 4'd0, 3'b011, 2'b01, 64'd77, 8'hFF, 0, 0, 0, -1, resp);
        chk("recover_bresp", resp, 2'b00);
        chk("recover_bursts", burst_count, 16'd1);
        chk("recover_beats", beat_count, 32'd1);
        rd_check(70, 64'd77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wr_slave_ram.md
# axi_wr_slave_ram

AXI3 write-channel responder that terminates 64-bit INCR bursts from the DMA write master into an on-chip word memory. It provides a registered readback port and capture counters. Its role is to act as the memory-side endpoint for the capture path in simulation and bring-up, in place of the PS DDR port. It handles one outstanding burst at a time, with full AW/W/B handshaking and byte-strobe writes.

## Interface
Parameters:
- ADDR_BASE, 32'h0000_0000, byte address mapped to memory word 0; must be 8-byte aligned.
- DEPTH_WORDS, 256, memory depth in 64-bit words; power of two, ≥16.

Ports (one clock; reset is asynchronous and active-low):
- aclk  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_axi_awaddr  in  32  burst start byte address
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_awlen  in  4  beats minus one
- s_axi_awsize  in  3  must be 3'b011
- s_axi_awburst  in  2  must be 2'b01 (INCR)
- s_axi_wdata  in  64  write data
- s_axi_wstrb  in  8  byte enables
- s_axi_wlast  in  1  last beat flag
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rd_addr_i  in  $clog2(DEPTH_WORDS)  readback word index
- rd_data_o  out  64  readback data, 1-cycle latency
- beat_count_o  out  32  accepted W beats, wraps at 2^32
- burst_count_o  out  16  completed B handshakes, wraps
- proto_err_o  out  1  sticky protocol-violation flag

## Operation
- FSM states: IDLE, DATA, RESP.
- IDLE: awready=1. On AW handshake:
  - latch start word = (awaddr−ADDR_BASE)>>3, len=awlen, beat=0.
  - evaluate the burst's error flag.
  - go to DATA.
- DATA: wready=1. On each W handshake:
  - if the burst's error flag is clear, write mem[(start+beat) mod DEPTH_WORDS], honoring wstrb per byte;
  - beat_count_o+1; beat+1.
  - On the handshake with beat==len, go to RESP.
  - Burst termination follows awlen only; wlast never ends a burst.
- RESP: bvalid=1, bresp=SLVERR if the burst's error flag is set, else OKAY. Hold until bready. On B handshake: burst_count_o+1, go to IDLE.
- Unsupported burst (awsize≠3'b011 or awburst≠2'b01):
  - sets the burst's error flag;
  - the burst still consumes len+1 beats;
  - all writes are suppressed;
  - proto_err_o is set.
- wlast mismatch sets proto_err_o:
  - wlast=1 on beat<len, or
  - wlast=0 on beat==len.
- proto_err_o clears only on reset.
- Only one burst is outstanding: awready=0 in DATA and RESP.
- Readback: rd_data_o <= mem[rd_addr_i] every cycle. A write and a read to the same word in the same cycle return old data.
- awaddr bits [2:0] are ignored.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=00, rd_data_o=0, beat_count_o=0, burst_count_o=0, proto_err_o=0, state IDLE.
- awready rises on the first aclk edge after rst_ni deasserts.
- Memory is not reset; contents survive reset.
- AW handshake at edge N → wready=1 from N+1.
- Last-beat handshake at edge M → bvalid=1 from M+1; wready=0 from M+1.
- B handshake at edge K → awready=1 from K+1.
- Minimum cycle for a 16-beat burst: 1 AW + 16 W + 1 B = 18 cycles.
- All outputs are registered; no combinational input→output paths.
- Reset mid-burst:
  - state returns to IDLE immediately;
  - the partial burst is abandoned with no B;
  - words already written keep their values.

## Configuration
- AXI_WR_SLAVE_RANGE_CHK_EN defined:
  - sets the burst's error flag when awaddr<ADDR_BASE or start+len ≥ DEPTH_WORDS;
  - the burst is fully accepted, writes are suppressed, bresp=SLVERR;
  - proto_err_o is unchanged.
- Not defined: no range check; addresses wrap modulo DEPTH_WORDS; out-of-window bursts return OKAY.

## Test plan
- Basic burst:
  - Stimulus: awaddr=ADDR_BASE, awlen=15, wdata=0..15, wstrb=FF, bready=1, no stalls.
  - Response: rd_addr 0..15 reads back 0..15; bvalid on the cycle after beat 15; bresp=00; beat_count_o=16; burst_count_o=1.
- Backpressure:
  - Stimulus: wvalid low every 4th cycle; bready held low for 5 cycles.
  - Response: bvalid held steady for 5 cycles; awready=0 until the B handshake, then 1 on the next cycle; second burst at +128 bytes lands at words 16..31.
- Byte strobes:
  - Stimulus: word 0 preloaded with all-ones, then wdata=0, wstrb=0x0F.
  - Response: rd_data_o=0xFFFFFFFF_00000000.
- Unsupported size:
  - Stimulus: awsize=3'b010.
  - Response: 16 beats accepted; memory unchanged; bresp=10; proto_err_o=1.
- Early wlast:
  - Stimulus: wlast=1 on beat 3, awlen=15.
  - Response: proto_err_o=1; 16 beats still accepted; bresp=00.
- Range and reset:
  - Stimulus: awaddr=ADDR_BASE+8·(DEPTH_WORDS−8), awlen=15.
  - With AXI_WR_SLAVE_RANGE_CHK_EN: SLVERR and no writes.
  - Without it: words DEPTH−8..DEPTH−1 and 0..7 are written, bresp=00.
  - Assert rst_ni low at beat 5: no bvalid; beats 0..4 retained; counters read 0.
